// File: rtl/init_cmd_encoder.sv
// -----------------------------------------------------------------------------
// init_cmd_encoder
//
// Turns the DDR4 init-sequencer command requests into registered DDR4 command
// pins. It also tracks which mode registers have been written, captures the
// CL/CWL/AL/BL fields, and flags protocol violations: tMRD/tMOD spacing,
// conflicting requests, an invalid MR select, and out-of-order commands.
//
// Parameters
//   TMRD      minimum CK_t cycles between successive MRS commands
//   TMOD      minimum CK_t cycles from the last MRS to ZQCL
//
// Ports
//   CK_t                      in   clock, rising edge
//   reset_n                   in   synchronous active-low reset
//   des_rdy/mrs_rdy/zqcl_rdy  in   command requests (at most one per cycle)
//   ini_done                  in   init-sequencer completion flag
//   mode_reg[21:0]            in   [20:18] MR select {BG0,BA1,BA0}, [17:0] A17..A0
//   CS_n..WE_n, BG, BA, ADDR  out  registered command pins
//   mr_valid[6:0]             out  bit n set once MRn has been issued
//   cl/cwl/al/bl_code         out  captured MR0/MR1/MR2 fields
//   cfg_valid                 out  init complete, all MRs written, no errors
//   cmd_err                   out  sticky protocol-violation flag
// -----------------------------------------------------------------------------
module init_cmd_encoder #(
  parameter int TMRD = 8,
  parameter int TMOD = 24
) (
  input  logic        CK_t,
  input  logic        reset_n,
  input  logic        des_rdy,
  input  logic        mrs_rdy,
  input  logic        zqcl_rdy,
  input  logic        ini_done,
  input  logic [21:0] mode_reg,
  output logic        CS_n,
  output logic        ACT_n,
  output logic        RAS_n,
  output logic        CAS_n,
  output logic        WE_n,
  output logic [1:0]  BG,
  output logic [1:0]  BA,
  output logic [17:0] ADDR,
  output logic [6:0]  mr_valid,
  output logic [3:0]  cl_code,
  output logic [2:0]  cwl_code,
  output logic [1:0]  al_code,
  output logic [1:0]  bl_code,
  output logic        cfg_valid,
  output logic        cmd_err
);

  typedef enum logic [1:0] {IDLE, CONFIG, ZQ_WAIT, DONE} state_t;

  localparam logic [5:0] TMRD_M1 = 6'(TMRD - 1);
  localparam logic [5:0] TMOD_M1 = 6'(TMOD - 1);

  // Pin bundle order: {CS_n, ACT_n, RAS_n, CAS_n, WE_n}
  localparam logic [4:0] CMD_DES  = 5'b11111;
  localparam logic [4:0] CMD_MRS  = 5'b01000;
  localparam logic [4:0] CMD_ZQCL = 5'b01110;

  state_t      state_q, state_d;
  logic [4:0]  cmd_q, cmd_d;
  logic [1:0]  bg_q, bg_d;
  logic [1:0]  ba_q, ba_d;
  logic [17:0] addr_q, addr_d;
  logic [6:0]  mr_valid_q, mr_valid_d;
  logic [3:0]  cl_code_q, cl_code_d;
  logic [2:0]  cwl_code_q, cwl_code_d;
  logic [1:0]  al_code_q, al_code_d;
  logic [1:0]  bl_code_q, bl_code_d;
  logic        cfg_valid_q, cfg_valid_d;
  logic        cmd_err_q, cmd_err_d;
  logic [5:0]  gap_q, gap_d;

  logic [1:0]  n_req;
  logic [2:0]  mr_sel;
  logic [17:0] mr_a;
  logic        unused_rsvd;

  assign n_req       = {1'b0, des_rdy} + {1'b0, mrs_rdy} + {1'b0, zqcl_rdy};
  assign mr_sel      = mode_reg[20:18];
  assign mr_a        = mode_reg[17:0];
  assign unused_rsvd = mode_reg[21];

  always_comb begin
    state_d    = state_q;
    cmd_d      = CMD_DES;
    bg_d       = 2'b00;
    ba_d       = 2'b00;
    addr_d     = 18'h0;
    mr_valid_d = mr_valid_q;
    cl_code_d  = cl_code_q;
    cwl_code_d = cwl_code_q;
    al_code_d  = al_code_q;
    bl_code_d  = bl_code_q;
    cmd_err_d  = cmd_err_q;
    gap_d      = (gap_q == 6'd63) ? gap_q : gap_q + 6'd1;

    // DONE ignores every request and the completion flag (which the
    // sequencer may leave asserted); the pins just keep driving DES.
    if (state_q != DONE) begin
      if (n_req > 2'd1) begin
        // Conflicting requests: nothing is issued.
        cmd_err_d = 1'b1;
      end else if (mrs_rdy) begin
        cmd_d  = CMD_MRS;
        bg_d   = {1'b0, mr_sel[2]};
        ba_d   = mr_sel[1:0];
        addr_d = mr_a;
        gap_d  = 6'd0;
        if (gap_q < TMRD_M1)     cmd_err_d = 1'b1;
        if (state_q == ZQ_WAIT)  cmd_err_d = 1'b1;
        if (mr_sel == 3'd7) begin
          cmd_err_d = 1'b1;
        end else begin
          for (int i = 0; i < 7; i++) begin
            if (mr_sel == 3'(i)) mr_valid_d[i] = 1'b1;
          end
        end
        case (mr_sel)
          3'd0: begin
            cl_code_d = {mr_a[6], mr_a[5], mr_a[4], mr_a[2]};
            bl_code_d = mr_a[1:0];
          end
          3'd1:    al_code_d  = mr_a[4:3];
          3'd2:    cwl_code_d = mr_a[5:3];
          default: ;
        endcase
        if (state_q == IDLE) state_d = CONFIG;
      end else if (zqcl_rdy) begin
        cmd_d      = CMD_ZQCL;
        addr_d[10] = 1'b1;
        // In IDLE mr_valid cannot be complete, so this also flags ZQCL there.
        if (gap_q < TMOD_M1 || mr_valid_q != 7'h7F) cmd_err_d = 1'b1;
        if (state_q == ZQ_WAIT) cmd_err_d = 1'b1;
        if (state_q == CONFIG)  state_d   = ZQ_WAIT;
      end

      if (ini_done) begin
        if (state_q == ZQ_WAIT) state_d   = DONE;
        else                    cmd_err_d = 1'b1;
      end
    end

    cfg_valid_d = (state_d == DONE) && (mr_valid_d == 7'h7F) && !cmd_err_d;
  end

  always_ff @(posedge CK_t) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cmd_q       <= CMD_DES;
      bg_q        <= 2'b00;
      ba_q        <= 2'b00;
      addr_q      <= 18'h0;
      mr_valid_q  <= 7'h0;
      cl_code_q   <= 4'h0;
      cwl_code_q  <= 3'h0;
      al_code_q   <= 2'h0;
      bl_code_q   <= 2'h0;
      cfg_valid_q <= 1'b0;
      cmd_err_q   <= 1'b0;
      gap_q       <= 6'd63;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      bg_q        <= bg_d;
      ba_q        <= ba_d;
      addr_q      <= addr_d;
      mr_valid_q  <= mr_valid_d;
      cl_code_q   <= cl_code_d;
      cwl_code_q  <= cwl_code_d;
      al_code_q   <= al_code_d;
      bl_code_q   <= bl_code_d;
      cfg_valid_q <= cfg_valid_d;
      cmd_err_q   <= cmd_err_d;
      gap_q       <= gap_d;
    end
  end

  assign {CS_n, ACT_n, RAS_n, CAS_n, WE_n} = cmd_q;
  assign BG        = bg_q;
  assign BA        = ba_q;
  assign ADDR      = addr_q;
  assign mr_valid  = mr_valid_q;
  assign cl_code   = cl_code_q;
  assign cwl_code  = cwl_code_q;
  assign al_code   = al_code_q;
  assign bl_code   = bl_code_q;
  assign cfg_valid = cfg_valid_q;
  assign cmd_err   = cmd_err_q;

endmodule

// File: tb/tb_init_cmd_encoder.sv
module tb_init_cmd_encoder;

  logic        CK_t = 1'b0;
  logic        reset_n = 1'b0;
  logic        des_rdy = 1'b0, mrs_rdy = 1'b0, zqcl_rdy = 1'b0, ini_done = 1'b0;
  logic [21:0] mode_reg = 22'h0;
  logic        CS_n, ACT_n, RAS_n, CAS_n, WE_n;
  logic [1:0]  BG, BA;
  logic [17:0] ADDR;
  logic [6:0]  mr_valid;
  logic [3:0]  cl_code;
  logic [2:0]  cwl_code;
  logic [1:0]  al_code, bl_code;
  logic        cfg_valid, cmd_err;

  localparam logic [4:0] P_DES  = 5'b11111;
  localparam logic [4:0] P_MRS  = 5'b01000;
  localparam logic [4:0] P_ZQCL = 5'b01110;

  int n_cmp = 0;
  int n_bad = 0;

  init_cmd_encoder #(.TMRD(8), .TMOD(24)) dut (
    .CK_t(CK_t), .reset_n(reset_n),
    .des_rdy(des_rdy), .mrs_rdy(mrs_rdy), .zqcl_rdy(zqcl_rdy),
    .ini_done(ini_done), .mode_reg(mode_reg),
    .CS_n(CS_n), .ACT_n(ACT_n), .RAS_n(RAS_n), .CAS_n(CAS_n), .WE_n(WE_n),
    .BG(BG), .BA(BA), .ADDR(ADDR), .mr_valid(mr_valid),
    .cl_code(cl_code), .cwl_code(cwl_code), .al_code(al_code), .bl_code(bl_code),
    .cfg_valid(cfg_valid), .cmd_err(cmd_err)
  );

  always #5 CK_t = ~CK_t;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [4:0] pins();
    return {CS_n, ACT_n, RAS_n, CAS_n, WE_n};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CK_t);
    #1;
  endtask

  task automatic idle(input int n);
    des_rdy = 0; mrs_rdy = 0; zqcl_rdy = 0; ini_done = 0; mode_reg = 22'h0;
    repeat (n) tick();
  endtask

  task automatic mrs(input logic [2:0] sel, input logic [17:0] a);
    mode_reg = {1'b0, sel, a};
    mrs_rdy  = 1;
    tick();
    mrs_rdy  = 0;
    mode_reg = 22'h0;
  endtask

  task automatic zq();
    zqcl_rdy = 1;
    tick();
    zqcl_rdy = 0;
  endtask

  task automatic done_pulse();
    ini_done = 1;
    tick();
    ini_done = 0;
  endtask

  task automatic do_reset();
    reset_n = 0;
    idle(2);
    reset_n = 1;
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_pins"}, {27'h0, pins()}, {27'h0, P_DES});
    check_eq({tag, "_bgbaaddr"}, {10'h0, BG, BA, ADDR}, 32'h0);
    check_eq({tag, "_mrv"}, {25'h0, mr_valid}, 32'h0);
    check_eq({tag, "_codes"}, {21'h0, cl_code, cwl_code, al_code, bl_code}, 32'h0);
    check_eq({tag, "_cfg_err"}, {30'h0, cfg_valid, cmd_err}, 32'h0);
  endtask

  initial begin
    // Reset state
    do_reset();
    check_reset_vals("rst");

    // Legal init: MR3,6,5,4,2,1,0 spaced 9 cycles, ZQCL 25 cycles after MR0
    idle(1);
    mrs(3'd3, 18'h0);  // mode_reg = 22'h0C0000
    check_eq("mr3_pins", {27'h0, pins()}, {27'h0, P_MRS});
    check_eq("mr3_bgba", {28'h0, BG, BA}, 32'h3);
    check_eq("mr3_addr", {14'h0, ADDR}, 32'h0);
    check_eq("mr3_mrv", {25'h0, mr_valid}, 32'h08);
    idle(1);
    check_eq("des_after_mrs", {27'h0, pins()}, {27'h0, P_DES});
    idle(7);
    mrs(3'd6, 18'h3FFFF);
    check_eq("mr6_bgba", {28'h0, BG, BA}, 32'h6);
    check_eq("mr6_addr", {14'h0, ADDR}, 32'h3FFFF);
    idle(8); mrs(3'd5, 18'h0);
    idle(8); mrs(3'd4, 18'h0);
    idle(8); mrs(3'd2, 18'h00028);
    check_eq("cwl", {29'h0, cwl_code}, 32'h5);
    idle(8); mrs(3'd1, 18'h00018);
    check_eq("al", {30'h0, al_code}, 32'h3);
    idle(8); mrs(3'd0, 18'h00056);
    check_eq("cl", {28'h0, cl_code}, 32'hB);
    check_eq("bl", {30'h0, bl_code}, 32'h2);
    check_eq("legal_err_mrs", {31'h0, cmd_err}, 32'h0);
    idle(24);
    zq();
    check_eq("zq_pins", {27'h0, pins()}, {27'h0, P_ZQCL});
    check_eq("zq_addr", {10'h0, BG, BA, ADDR}, 32'h00400);
    check_eq("zq_err", {31'h0, cmd_err}, 32'h0);
    idle(2);
    check_eq("zqwait_cfg", {31'h0, cfg_valid}, 32'h0);
    done_pulse();
    check_eq("done_mrv", {25'h0, mr_valid}, 32'h7F);
    check_eq("done_cfg", {31'h0, cfg_valid}, 32'h1);
    check_eq("done_err", {31'h0, cmd_err}, 32'h0);
    mrs(3'd3, 18'h00123);
    check_eq("done_ignore_pins", {27'h0, pins()}, {27'h0, P_DES});
    check_eq("done_ignore_cfg", {30'h0, cfg_valid, cmd_err}, 32'h2);

    // Two MRS 3 cycles apart
    do_reset();
    idle(1);
    mrs(3'd3, 18'h0);
    check_eq("mrd_first_err", {31'h0, cmd_err}, 32'h0);
    idle(2);
    mrs(3'd2, 18'h0);
    check_eq("mrd_second_pins", {27'h0, pins()}, {27'h0, P_MRS});
    check_eq("mrd_second_err", {31'h0, cmd_err}, 32'h1);
    idle(5);
    check_eq("err_sticky", {31'h0, cmd_err}, 32'h1);

    // tMRD boundary: spacing 8 legal, spacing 7 flagged
    do_reset();
    idle(1);
    mrs(3'd3, 18'h0);
    idle(7); mrs(3'd4, 18'h0);
    check_eq("mrd_gap8_err", {31'h0, cmd_err}, 32'h0);
    idle(6); mrs(3'd5, 18'h0);
    check_eq("mrd_gap7_err", {31'h0, cmd_err}, 32'h1);
    check_eq("mrd_gap7_mrv", {25'h0, mr_valid}, 32'h38);

    // Conflicting requests
    do_reset();
    idle(1);
    mode_reg = 22'h0C0000; mrs_rdy = 1; zqcl_rdy = 1;
    tick();
    mrs_rdy = 0; zqcl_rdy = 0;
    check_eq("conflict_pins", {27'h0, pins()}, {27'h0, P_DES});
    check_eq("conflict_err", {31'h0, cmd_err}, 32'h1);
    check_eq("conflict_mrv", {25'h0, mr_valid}, 32'h0);

    // MR select 7 is issued but flagged
    do_reset();
    idle(1);
    mrs(3'd7, 18'h00001);
    check_eq("sel7_pins", {27'h0, pins()}, {27'h0, P_MRS});
    check_eq("sel7_bgba", {28'h0, BG, BA}, 32'h7);
    check_eq("sel7_err_mrv", {24'h0, mr_valid, cmd_err}, 32'h1);

    // MR0 field capture, then ZQCL before MR1 is written
    do_reset();
    idle(1);
    mrs(3'd0, 18'h00056);
    check_eq("mr0_cl", {28'h0, cl_code}, 32'hB);
    check_eq("mr0_bl", {30'h0, bl_code}, 32'h2);
    idle(24);
    zq();
    check_eq("early_zq_pins", {27'h0, pins()}, {27'h0, P_ZQCL});
    check_eq("early_zq_err", {31'h0, cmd_err}, 32'h1);
    done_pulse();
    check_eq("early_zq_cfg", {31'h0, cfg_valid}, 32'h0);

    // Reset while in ZQ_WAIT
    do_reset();
    idle(1);
    mrs(3'd1, 18'h00008);
    idle(24);
    zq();
    reset_n = 0;
    tick();
    check_reset_vals("rst_zqwait");
    reset_n = 1;
    tick();
    check_eq("post_rst_des", {27'h0, pins()}, {27'h0, P_DES});
    // Back in IDLE, so ini_done is now out of order
    done_pulse();
    check_eq("post_rst_ini_err", {30'h0, cfg_valid, cmd_err}, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/init_cmd_encoder.md
INIT_CMD_ENCODER -- requirements
Module: init_cmd_encoder

Interface
REQ-001 Parameter TMRD, default 8: minimum CK_t cycles between successive MRS commands.
REQ-002 Parameter TMOD, default 24: minimum CK_t cycles from the last MRS to ZQCL.
REQ-003 CK_t  input  1  single clock; all logic on rising edge.
REQ-004 reset_n  input  1  synchronous, active-low reset.
REQ-005 des_rdy, mrs_rdy, zqcl_rdy  input  1 each  init-sequencer command requests.
REQ-006 ini_done  input  1  init-sequencer completion flag.
REQ-007 mode_reg  input  22  [21] reserved, [20:18] MR select {BG0,BA1,BA0}, [17:0] A17..A0; sampled only when mrs_rdy=1.
REQ-008 CS_n, ACT_n, RAS_n, CAS_n, WE_n  output  1 each  registered DDR4 command pins.
REQ-009 BG  output  2  bank group; BA  output  2  bank address; ADDR  output  18  A17..A0.
REQ-010 mr_valid  output  7  bit n set once MRn has been issued.
REQ-011 cl_code 4, cwl_code 3, al_code 2, bl_code 2  outputs  captured MR fields.
REQ-012 cfg_valid  output  1  init configuration complete and consistent.
REQ-013 cmd_err  output  1  sticky protocol-violation flag.

Function
REQ-014 All pin outputs registered; command appears exactly 1 CK_t cycle after the request cycle.
REQ-015 Request cycle with no request bit set, or only des_rdy: DES (CS_n=1, ACT_n/RAS_n/CAS_n/WE_n=1, BG/BA/ADDR=0).
REQ-016 mrs_rdy alone: MRS (CS_n=0, ACT_n=1, RAS_n=0, CAS_n=0, WE_n=0); BG={1'b0,mode_reg[20]}, BA=mode_reg[19:18], ADDR=mode_reg[17:0].
REQ-017 zqcl_rdy alone: ZQCL (CS_n=0, ACT_n=1, RAS_n=1, CAS_n=1, WE_n=0); ADDR[10]=1, other ADDR/BG/BA=0.
REQ-018 Two or more of des_rdy/mrs_rdy/zqcl_rdy set in one cycle: DES issued, cmd_err set.
REQ-019 FSM states: IDLE, CONFIG, ZQ_WAIT, DONE; reset enters IDLE.
REQ-020 IDLE -> CONFIG on first accepted MRS; MRS and ZQCL are both legal in IDLE (ZQCL there triggers REQ-024).
REQ-021 CONFIG -> ZQ_WAIT on accepted ZQCL; further MRS in CONFIG legal subject to REQ-023.
REQ-022 ZQ_WAIT -> DONE when ini_done=1; MRS or ZQCL in ZQ_WAIT: command issued, cmd_err set.
REQ-023 Gap counter: 6-bit, cleared on each MRS, increments per cycle, saturates at 63; MRS with counter < TMRD-1 since previous MRS: command still issued, cmd_err set.
REQ-024 ZQCL with counter < TMOD-1, or with mr_valid != 7'h7F: command still issued, cmd_err set.
REQ-025 On MRS with select n (0..6): mr_valid[n] set; select 7: command issued, cmd_err set, no mr_valid change.
REQ-026 Field capture on MRS: MR0 -> cl_code={A6,A5,A4,A2}, bl_code=A[1:0]; MR1 -> al_code=A[4:3]; MR2 -> cwl_code=A[5:3]; repeat writes overwrite.
REQ-027 ini_done=1 outside ZQ_WAIT: cmd_err set, state unchanged.
REQ-028 DONE: pins hold DES; cfg_valid=1 iff mr_valid=7'h7F and cmd_err=0; all requests ignored.
REQ-029 cmd_err clears only on reset.

Reset
REQ-030 reset_n=0 at an edge: state IDLE, CS_n=1, ACT_n/RAS_n/CAS_n/WE_n=1, BG/BA/ADDR=0, mr_valid=0, cl/cwl/al/bl codes=0, cfg_valid=0, cmd_err=0, gap counter=63.
REQ-031 Reset mid-sequence (any state) has the same effect as REQ-030; the next cycle after release outputs DES.

Verification
REQ-032 Legal init: MR3,6,5,4,2,1,0 spaced 9 cycles, ZQCL 25 cycles later, ini_done -> mr_valid=7'h7F, cfg_valid=1, cmd_err=0.
REQ-033 MRS with mode_reg=22'h0C0000 -> next cycle CS_n=0, RAS_n=CAS_n=WE_n=0, BG=2'b00, BA=2'b11, ADDR=0, mr_valid[3]=1.
REQ-034 Two MRS 3 cycles apart -> second issued, cmd_err=1 from the cycle after it.
REQ-035 mrs_rdy and zqcl_rdy together -> DES on pins, cmd_err=1.
REQ-036 MR0 with A[6:4]=3'b101, A2=1, A[1:0]=2'b10 -> cl_code=4'b1011, bl_code=2'b10; ZQCL before MR1 -> cmd_err=1, cfg_valid stays 0.
REQ-037 reset_n=0 in ZQ_WAIT -> all outputs at REQ-030 values next cycle.
